// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        REDIRECT   = 2'd2,
        MEM_WAIT   = 2'd3
    } state_e;

    // Hazard events; a larger encoding wins when several fire in one cycle.
    typedef enum logic [2:0] {
        EV_NONE     = 3'd0,
        EV_LOAD_USE = 3'd1,
        EV_JUMP     = 3'd2,
        EV_BRANCH   = 3'd3,
        EV_MEM      = 3'd4
    } event_e;

    function automatic logic load_use_hit(
        input logic             mem_read,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt
    );
        return mem_read && (ex_rt != '0) && ((ex_rt == rs) || (ex_rt == rt));
    endfunction

    function automatic event_e classify(
        input logic mem_busy,
        input logic branch,
        input logic jump,
        input logic load_use
    );
        if (mem_busy)      return EV_MEM;
        else if (branch)   return EV_BRANCH;
        else if (jump)     return EV_JUMP;
        else if (load_use) return EV_LOAD_USE;
        else               return EV_NONE;
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Stall-cycle and flush-event counters; both wrap at 2^32.
module hazard_perf_counter
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    logic flush_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
            flush_prev   <= 1'b0;
        end else begin
            stall_cycles <= stall_cycles + CNT_W'(!pc_write);
            flush_events <= flush_events + CNT_W'(if_id_flush && !flush_prev);
            flush_prev   <= if_id_flush;
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: redirects, load-use stalls and memory waits.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_sequencer
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_jump,
    input  logic [PC_W-1:0]  id_jump_target,
    input  logic             ex_branch_taken,
    input  logic [PC_W-1:0]  ex_branch_target,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             pc_redirect,
    output logic [PC_W-1:0]  redirect_target,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    state_e           state_q, state_d;
    state_e           resume_q, resume_d;
    state_e           active_s;
    event_e           evt;
    logic [PC_W-1:0]  target_d;

    // After a memory wait the released cycle behaves as the state it froze.
    always_comb begin
        active_s = (state_q == MEM_WAIT) ? resume_q : state_q;
        evt = classify(mem_busy,
                       (active_s != REDIRECT) && ex_branch_taken,
                       (active_s != REDIRECT) && id_jump,
                       (active_s == RUN) &&
                           load_use_hit(id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= RUN;
            resume_q        <= RUN;
            redirect_target <= '0;
        end else begin
            state_q         <= state_d;
            resume_q        <= resume_d;
            redirect_target <= target_d;
        end
    end

    always_comb begin
        state_d  = RUN;
        resume_d = resume_q;
        target_d = redirect_target;
        case (evt)
            EV_MEM: begin
                state_d  = MEM_WAIT;
                resume_d = (state_q == MEM_WAIT) ? resume_q : state_q;
            end
            EV_BRANCH: begin
                state_d  = REDIRECT;
                target_d = ex_branch_target;
            end
            EV_JUMP: begin
                state_d  = REDIRECT;
                target_d = id_jump_target;
            end
            EV_LOAD_USE: state_d = LOAD_STALL;
            default:     state_d = RUN;
        endcase
    end

    // Reset forces the RUN defaults regardless of the state being left.
    always_comb begin
        pc_write     = 1'b1;
        pc_redirect  = 1'b0;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        if (!reset) begin
            case (evt)
                EV_MEM: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                end
                EV_BRANCH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                EV_JUMP: if_id_flush = 1'b1;
                EV_LOAD_USE: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
                default: begin
                    if (active_s == REDIRECT) begin
                        pc_redirect = 1'b1;
                        if_id_flush = 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter u_perf (
        .clk          (clk),
        .reset        (reset),
        .pc_write     (pc_write),
        .if_id_flush  (if_id_flush),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer against a flag-based behavioural model.
module tb_hazard_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_jump;
    logic [31:0] id_jump_target;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic        mem_busy;
    logic        pc_write;
    logic        pc_redirect;
    logic [31:0] redirect_target;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_write;
    logic        id_ex_flush;
    logic        ex_mem_write;
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;

    int checks   = 0;
    int failures = 0;

    // Model: a redirect owed next cycle, a just-stalled flag, the target and counters.
    bit          m_pending;
    bit          m_after_stall;
    logic [31:0] m_target;
    logic [31:0] m_stall;
    logic [31:0] m_flush;
    bit          m_prev_flush;

    hazard_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .id_jump          (id_jump),
        .id_jump_target   (id_jump_target),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_rt         (id_ex_rt),
        .if_id_rs         (if_id_rs),
        .if_id_rt         (if_id_rt),
        .mem_busy         (mem_busy),
        .pc_write         (pc_write),
        .pc_redirect      (pc_redirect),
        .redirect_target  (redirect_target),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_write      (id_ex_write),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_write     (ex_mem_write),
        .stall_cycles     (stall_cycles),
        .flush_events     (flush_events)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit jmp, input logic [31:0] jt,
                        input bit br, input logic [31:0] bt, input bit mr,
                        input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input bit busy);
        bit e_pw, e_pr, e_ifw, e_iff, e_idw, e_idf, e_exw, lu;
        @(negedge clk);
        reset = rst; id_jump = jmp; id_jump_target = jt;
        ex_branch_taken = br; ex_branch_target = bt;
        id_ex_mem_read = mr; id_ex_rt = ert; if_id_rs = rs; if_id_rt = rt;
        mem_busy = busy;
        #1;
        e_pw = 1; e_pr = 0; e_ifw = 1; e_iff = 0; e_idw = 1; e_idf = 0; e_exw = 1;
        lu = mr && (ert != 0) && (ert == rs || ert == rt);
        if (!rst) begin
            if (busy) begin
                e_pw = 0; e_ifw = 0; e_idw = 0; e_exw = 0;
            end else if (m_pending) begin
                e_pr = 1; e_iff = 1;
            end else if (br) begin
                e_iff = 1; e_idf = 1;
            end else if (jmp) begin
                e_iff = 1;
            end else if (lu && !m_after_stall) begin
                e_pw = 0; e_ifw = 0; e_idf = 1;
            end
        end
        check("pc_write",     32'(pc_write),     32'(e_pw));
        check("pc_redirect",  32'(pc_redirect),  32'(e_pr));
        check("if_id_write",  32'(if_id_write),  32'(e_ifw));
        check("if_id_flush",  32'(if_id_flush),  32'(e_iff));
        check("id_ex_write",  32'(id_ex_write),  32'(e_idw));
        check("id_ex_flush",  32'(id_ex_flush),  32'(e_idf));
        check("ex_mem_write", 32'(ex_mem_write), 32'(e_exw));
        check("redirect_target", redirect_target, m_target);
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cycles", stall_cycles, m_stall);
        check("flush_events", flush_events, m_flush);
`else
        check("stall_cycles", stall_cycles, 32'd0);
        check("flush_events", flush_events, 32'd0);
`endif
        if (rst) begin
            m_pending = 0; m_after_stall = 0; m_target = '0;
            m_stall = '0; m_flush = '0; m_prev_flush = 0;
        end else begin
            m_stall = m_stall + 32'(!e_pw);
            m_flush = m_flush + 32'(e_iff && !m_prev_flush);
            m_prev_flush = e_iff;
            if (!busy) begin
                if (m_pending) begin
                    m_pending = 0; m_after_stall = 0;
                end else if (br) begin
                    m_target = bt; m_pending = 1; m_after_stall = 0;
                end else if (jmp) begin
                    m_target = jt; m_pending = 1; m_after_stall = 0;
                end else if (lu && !m_after_stall) begin
                    m_after_stall = 1;
                end else begin
                    m_after_stall = 0;
                end
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    initial begin
        reset = 1'b1; id_jump = 0; id_jump_target = '0; ex_branch_taken = 0;
        ex_branch_target = '0; id_ex_mem_read = 0; id_ex_rt = '0;
        if_id_rs = '0; if_id_rt = '0; mem_busy = 0;
        m_pending = 0; m_after_stall = 0; m_target = '0;
        m_stall = '0; m_flush = '0; m_prev_flush = 0;
        repeat (2) @(posedge clk);

        step(1, 0, 32'h0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();

        // Load-use on rs, then the same pair again in the stall cycle.
        step(0, 0, 32'h0, 0, 32'h0, 1, 5'd8, 5'd8, 5'd1, 0);
        step(0, 0, 32'h0, 0, 32'h0, 1, 5'd8, 5'd8, 5'd1, 0);
        idle();
`ifdef HAZARD_PERF_CNT_EN
        check("tp_stall_cycles", stall_cycles, 32'd1);
`endif

        // Taken branch to 0x40.
        step(0, 0, 32'h0, 1, 32'h40, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();
        check("tp_branch_target", redirect_target, 32'h40);
        check("tp_branch_redirect", 32'(pc_redirect), 32'd1);
        idle();

        // Branch and jump together: the branch wins.
        step(0, 1, 32'h80, 1, 32'h40, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();
        check("tp_br_over_jump", redirect_target, 32'h40);

        // Memory wait starting in the redirect cycle.
        step(0, 1, 32'h100, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0);
        repeat (3) step(0, 0, 32'h0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 1);
        idle();
        check("tp_memwait_redirect", 32'(pc_redirect), 32'd1);
        check("tp_memwait_target", redirect_target, 32'h100);
        idle();

        // Zero register never stalls.
        step(0, 0, 32'h0, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0, 0);
        check("tp_zero_reg", 32'(pc_write), 32'd1);

        // Reset while in REDIRECT.
        step(0, 0, 32'h0, 1, 32'h200, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 32'h0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();
        check("tp_reset_target", redirect_target, 32'h0);
        check("tp_reset_redirect", 32'(pc_redirect), 32'd0);

        // Randomized traffic with collisions on a small register set.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 5) == 0, $urandom,
                 $urandom_range(0, 5) == 0, $urandom,
                 $urandom_range(0, 2) == 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
